list_sum_collector: RTL

//  Downstream stage of the linked-list pointer sequence generator.
//  - Consumes the back-to-back pointer stream, one pointer per cycle, with no backpressure.
//  - Looks up a per-node value in an internal value RAM and accumulates one sum per list.
//  - Emits one {head, count, sum} result per list through a valid/ready result FIFO.

---
 rtl/list_sum_collector_pkg.sv | 27 ++
 rtl/list_sum_collector_if.sv | 32 +++
 rtl/list_sum_collector_res_fifo.sv | 90 +++++++++
 rtl/list_sum_collector.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/list_sum_collector_pkg.sv
// list_pkg: shared widths, types and helpers for the list sum collector.
//   n       number of list nodes (pointer 0 is the null pointer)
//   w_ptr   pointer width, w_data node value width
//   ptr_t / data_t / cnt_t / sum_t and the list_res_t result record
package list_pkg;

  localparam int n      = 16;
  localparam int w_ptr  = $clog2(n);
  localparam int w_data = 8;

  typedef logic [w_ptr-1:0]        ptr_t;
  typedef logic [w_data-1:0]       data_t;
  typedef logic [w_ptr:0]          cnt_t;
  typedef logic [w_data+w_ptr-1:0] sum_t;

  typedef struct packed {
    ptr_t head;
    cnt_t cnt;
    sum_t sum;
  } list_res_t;

  // Node count increment that sticks at n.
  function automatic cnt_t cnt_inc_sat(input cnt_t c);
    return (c >= cnt_t'(n)) ? cnt_t'(n) : c + cnt_t'(1);
  endfunction

endpackage

// File: rtl/list_sum_collector_if.sv
// list_sum_collector_if: bundles the pointer stream, value-RAM write port,
// result handshake and sticky status of the list sum collector.
//   master: pointer source / RAM writer / result consumer
//   slave : the collector itself
interface list_sum_collector_if;
  import list_pkg::*;

  ptr_t  ptr;
  logic  ptr_vld;
  logic  ptr_last;
  logic  wr_en;
  ptr_t  wr_addr;
  data_t wr_data;
  ptr_t  res_head;
  cnt_t  res_cnt;
  sum_t  res_sum;
  logic  res_vld;
  logic  res_rdy;
  logic  ovf;
  logic  err;

  modport master (
    output ptr, ptr_vld, ptr_last, wr_en, wr_addr, wr_data, res_rdy,
    input  res_head, res_cnt, res_sum, res_vld, ovf, err
  );

  modport slave (
    input  ptr, ptr_vld, ptr_last, wr_en, wr_addr, wr_data, res_rdy,
    output res_head, res_cnt, res_sum, res_vld, ovf, err
  );

endinterface

// File: rtl/list_sum_collector_res_fifo.sv
// list_res_fifo: first-word-fall-through FIFO of list_res_t with a
// registered head.
//   clk, rst      clock, synchronous active-high reset
//   i_push/_data  write request and record
//   i_pop         consume the head (ignored when empty)
//   o_head        registered head record (zero when empty)
//   o_full        DEPTH entries held
//   o_empty       nothing held
//   o_push_drop   push refused this cycle (full and no pop)
module list_res_fifo
  import list_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  list_res_t i_push_data,
  input  logic      i_pop,
  output list_res_t o_head,
  output logic      o_full,
  output logic      o_empty,
  output logic      o_push_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  list_res_t       r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  list_res_t       r_head;
  logic            r_vld;

  logic            w_full;
  logic            w_pop;
  logic            w_push_ok;
  logic [AW-1:0]   w_rd_ptr_nxt;
  logic [AW-1:0]   w_wr_ptr_nxt;
  logic [CW-1:0]   w_count_nxt;
  list_res_t       w_head_nxt;

  // Next occupancy and the record that becomes the head after this edge.
  always_comb begin
    w_full       = (r_count == CW'(DEPTH));
    w_pop        = i_pop & r_vld;
    // A pop frees the slot, so a full FIFO still accepts a simultaneous push.
    w_push_ok    = i_push & (~w_full | w_pop);
    w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
    w_wr_ptr_nxt = r_wr_ptr + AW'(w_push_ok);
    w_count_nxt  = r_count + CW'(w_push_ok) - CW'(w_pop);
    if (w_count_nxt == {CW{1'b0}}) begin
      w_head_nxt = '0;
    end else if (w_push_ok && (r_wr_ptr == w_rd_ptr_nxt)) begin
      // The incoming record lands exactly in the next head slot: bypass it.
      w_head_nxt = i_push_data;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // Storage array: only accepted pushes are written.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= {AW{1'b0}};
      r_wr_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_head   <= '0;
      r_vld    <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
      r_head   <= w_head_nxt;
      r_vld    <= (w_count_nxt != {CW{1'b0}});
    end
  end

  assign o_head      = r_head;
  assign o_full      = w_full;
  assign o_empty     = ~r_vld;
  assign o_push_drop = i_push & w_full & ~w_pop;

endmodule

// File: rtl/list_sum_collector.sv
// list_sum_collector: sums per-node values over each linked list arriving as
// a back-to-back pointer stream and queues one {head, cnt, sum} per list.
//   clk, rst  clock, synchronous active-high reset
//   bus       list_sum_collector_if.slave: ptr/ptr_vld/ptr_last stream,
//             wr_en/wr_addr/wr_data value-RAM write, res_* result with
//             res_vld/res_rdy handshake, sticky ovf (result dropped) and
//             err (null pointer seen)
module list_sum_collector
  import list_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  list_sum_collector_if.slave  bus
);

  data_t     r_ram [n];
  data_t     r_rd_data;
  logic      r_s1_vld;
  logic      r_s1_last;
  logic      r_s1_first;
  ptr_t      r_s1_ptr;
  logic      r_open;
  sum_t      r_acc;
  cnt_t      r_cnt;
  ptr_t      r_head;
  logic      r_ovf;
  logic      r_err;

  logic      w_null;
  logic      w_accept;
  sum_t      w_acc_base;
  cnt_t      w_cnt_base;
  ptr_t      w_head_cur;
  sum_t      w_sum_nxt;
  cnt_t      w_cnt_nxt;
  logic      w_push;
  logic      w_pop;
  list_res_t w_push_data;
  list_res_t w_fifo_head;
  logic      w_fifo_empty;
  logic      w_fifo_full_unused;
  logic      w_push_drop;

  assign w_null   = bus.ptr_vld & (bus.ptr == {w_ptr{1'b0}});
  assign w_accept = bus.ptr_vld & ~w_null;

  // Value RAM (not reset): both ports sample old contents, so a same-address
  // write and read in one cycle returns the pre-write value.
  always_ff @(posedge clk) begin
    if (bus.wr_en) r_ram[bus.wr_addr] <= bus.wr_data;
    if (w_accept)  r_rd_data <= r_ram[bus.ptr];
  end

  // Stage-1 pipeline registers and stage-0 view of whether a list is open.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_ptr   <= {w_ptr{1'b0}};
      r_open     <= 1'b0;
    end else begin
      r_s1_vld   <= w_accept;
      r_s1_last  <= bus.ptr_last;
      r_s1_first <= ~r_open;
      r_s1_ptr   <= bus.ptr;
      // Tracked at stage 0 so a new head right after a last pointer sees closed.
      if (w_accept) r_open <= ~bus.ptr_last;
    end
  end

  // Stage-1 accumulate: a first node restarts sum, count and head.
  always_comb begin
    w_acc_base = r_acc;
    w_cnt_base = r_cnt;
    w_head_cur = r_head;
    if (r_s1_first) begin
      w_acc_base = {(w_data+w_ptr){1'b0}};
      w_cnt_base = {(w_ptr+1){1'b0}};
      w_head_cur = r_s1_ptr;
    end else begin
      w_acc_base = r_acc;
      w_cnt_base = r_cnt;
      w_head_cur = r_head;
    end
    w_sum_nxt = w_acc_base + sum_t'(r_rd_data);
    w_cnt_nxt = cnt_inc_sat(w_cnt_base);
  end

  // Running totals of the open list; a closing node goes to the FIFO instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= {(w_data+w_ptr){1'b0}};
      r_cnt  <= {(w_ptr+1){1'b0}};
      r_head <= {w_ptr{1'b0}};
    end else if (r_s1_vld && !r_s1_last) begin
      r_acc  <= w_sum_nxt;
      r_cnt  <= w_cnt_nxt;
      r_head <= w_head_cur;
    end
  end

  assign w_push      = r_s1_vld & r_s1_last;
  assign w_push_data = '{head: w_head_cur, cnt: w_cnt_nxt, sum: w_sum_nxt};
  assign w_pop       = ~w_fifo_empty & bus.res_rdy;

  list_res_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_full      (w_fifo_full_unused),
    .o_empty     (w_fifo_empty),
    .o_push_drop (w_push_drop)
  );

  // Sticky status flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ovf <= r_ovf | w_push_drop;
      r_err <= r_err | w_null;
    end
  end

  assign bus.res_head = w_fifo_head.head;
  assign bus.res_cnt  = w_fifo_head.cnt;
  assign bus.res_sum  = w_fifo_head.sum;
  assign bus.res_vld  = ~w_fifo_empty;
  assign bus.ovf      = r_ovf;
  assign bus.err      = r_err;

endmodule
